// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encodings, default widths and the NOP filler word
// for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int FIFO_D = 2;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry instruction buffer holding {instr, pc}; head reads
// as zero when empty and flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty;
  assign count  = r_cnt;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign dout   = empty ? '0 : r_mem[r_rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding-request instruction fetch with redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int FIFO_DEPTH = FIFO_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_enab,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e                          r_state, w_next;
  logic [ADDR_WIDTH-1:0]           r_req_pc;
  logic                            w_full, w_empty, w_push, w_pop, w_rsp, w_byp;
  logic [CW-1:0]                   w_count;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] w_head;
  assign w_rsp = imem_rsp_valid & ~redirect_valid & (r_state == WAIT_RSP);
`ifdef FETCH_BYPASS_EN
  assign w_byp = w_rsp & w_empty;
`else
  assign w_byp = 1'b0;
`endif
  // issue looks only at the registered count, so a same-cycle pop never frees a slot early
  assign imem_req_valid = rst & (r_state == IDLE) & (w_count < CW'(FIFO_DEPTH)) & ~redirect_valid;
  assign imem_req_addr  = imem_req_valid ? pc_in : '0;
  assign pc_enab        = imem_req_valid & imem_req_ready;
  assign pc_load        = rst & redirect_valid;
  assign pc_load_val    = pc_load ? redirect_pc : '0;
  assign if_valid       = ~w_empty | w_byp;
  assign {if_instr, if_pc} = ~w_empty ? w_head : w_byp ? {imem_rsp_data, r_req_pc} : '0;
  assign w_pop  = ~w_empty & if_ready & ~redirect_valid;
  assign w_push = w_rsp & ~w_full & ~(w_byp & if_ready);
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH + ADDR_WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   ({imem_rsp_data, r_req_pc}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= IDLE;
      r_req_pc <= '0;
    end else begin
      r_state <= w_next;
      if (pc_enab) r_req_pc <= pc_in;
    end
  // a redirect while waiting leaves the response in flight, so it must be dropped later
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = pc_enab ? WAIT_RSP : IDLE;
      WAIT_RSP: w_next = imem_rsp_valid ? IDLE : redirect_valid ? DROP : WAIT_RSP;
      DROP:     w_next = imem_rsp_valid ? IDLE : DROP;
      default:  w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a queue-based
// model of the fetch stage, the PC counter and an in-order instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 2;
  logic        clk, rst;
  logic [4:0]  pc_in, pc_load_val, imem_req_addr, redirect_pc, if_pc;
  logic        pc_enab, pc_load, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, if_valid, if_ready;
  logic [31:0] imem_rsp_data, if_instr;
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_enab(pc_enab), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  logic [4:0]  pc_m, m_addr;
  bit          m_out, m_kill, e_req, e_if;
  int          m_delay, lat = 1;
  logic [36:0] exp_q[$];
  function automatic logic [31:0] memword(input logic [4:0] a);
    return {a, 11'h5A3, a, 11'h013};
  endfunction
  task automatic drive(input bit rn, input bit rq_rdy, input bit ifr, input bit rd,
                       input logic [4:0] rpc);
    @(negedge clk);
    rst = rn;
    if (!rn) begin
      exp_q.delete();
      m_out = 0;
      m_kill = 0;
      pc_m = '0;
    end
    imem_req_ready = rq_rdy;
    if_ready = ifr;
    redirect_valid = rd;
    redirect_pc = rpc;
    pc_in = pc_m;
    imem_rsp_valid = m_out && m_delay == 0;
    imem_rsp_data = imem_rsp_valid ? memword(m_addr) : NOP_INSTR;
    e_req = rn && !m_out && exp_q.size() < DEPTH && !rd;
    e_if = exp_q.size() > 0;
    #1;
  endtask
  task automatic advance();
    bit acc, rsp, pop;
    acc = e_req && imem_req_ready;
    rsp = imem_rsp_valid;
    pop = e_if && if_ready;
    @(posedge clk);
    if (!rst) return;
    if (redirect_valid) begin
      exp_q.delete();
      if (m_out && !rsp) m_kill = 1;
      pc_m = redirect_pc;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rsp && !m_kill) exp_q.push_back({memword(m_addr), m_addr});
    end
    if (rsp) begin
      m_out = 0;
      m_kill = 0;
    end
    if (acc) begin
      m_out = 1;
      m_addr = pc_m;
      m_delay = lat - 1;
      pc_m = pc_m + 5'd1;
    end else if (m_out && m_delay > 0) m_delay--;
  endtask
  task automatic settle();
    repeat (5) begin
      drive(1, 0, 1, 0, '0);
      advance();
    end
  endtask
  task automatic test_reset();
    drive(0, 1, 1, 1, 5'h09);
    checks++; if ({imem_req_valid, pc_enab, pc_load, if_valid} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {imem_req_valid, pc_enab, pc_load, if_valid}); else passes++;
    checks++; if ({if_instr, if_pc, imem_req_addr, pc_load_val} !== '0) $display("FAIL reset_data: got %h want 0", {if_instr, if_pc, imem_req_addr, pc_load_val}); else passes++;
    advance();
  endtask
  task automatic test_stream();
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 1, 0, '0);
      checks++; if (imem_req_valid !== (k % 2 == 0)) $display("FAIL stream_req k=%0d: got %b want %b", k, imem_req_valid, k % 2 == 0); else passes++;
      checks++; if (pc_enab !== (k % 2 == 0)) $display("FAIL stream_enab k=%0d: got %b want %b", k, pc_enab, k % 2 == 0); else passes++;
      if (k % 2 == 0) begin
        checks++; if (imem_req_addr !== 5'(k / 2)) $display("FAIL stream_addr k=%0d: got %0d want %0d", k, imem_req_addr, k / 2); else passes++;
      end
      checks++; if (if_valid !== (k >= 2 && k % 2 == 0)) $display("FAIL stream_ifv k=%0d: got %b", k, if_valid); else passes++;
      if (k >= 2 && k % 2 == 0) begin
        checks++; if ({if_instr, if_pc} !== {memword(5'(k / 2 - 1)), 5'(k / 2 - 1)}) $display("FAIL stream_out k=%0d: got %h/%0d want pc %0d", k, if_instr, if_pc, k / 2 - 1); else passes++;
      end
      advance();
    end
  endtask
  task automatic test_backpressure();
    int n = 0;
    logic [4:0] p0;
    settle();
    p0 = pc_m;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, 0, 0, '0);
      if (imem_req_valid && imem_req_ready) n++;
      advance();
    end
    checks++; if (n !== 2) $display("FAIL bp_count: got %0d want 2", n); else passes++;
    drive(1, 1, 1, 0, '0);
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL bp_full_pop_req: got %b want 0", imem_req_valid); else passes++;
    checks++; if (if_pc !== p0 || if_valid !== 1'b1) $display("FAIL bp_head: got %b/%0d want 1/%0d", if_valid, if_pc, p0); else passes++;
    advance();
    drive(1, 1, 0, 0, '0);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== p0 + 5'd2) $display("FAIL bp_resume: got %b/%0d want 1/%0d", imem_req_valid, imem_req_addr, p0 + 5'd2); else passes++;
    advance();
    settle();
  endtask
  task automatic test_req_stall();
    logic [4:0] p0;
    settle();
    p0 = pc_m;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, '0);
      checks++; if ({imem_req_valid, imem_req_addr, pc_enab} !== {1'b1, p0, 1'b0}) $display("FAIL stall_hold k=%0d: got %b/%0d/%b want 1/%0d/0", k, imem_req_valid, imem_req_addr, pc_enab, p0); else passes++;
      advance();
    end
    drive(1, 1, 1, 0, '0);
    checks++; if (pc_enab !== 1'b1 || imem_req_addr !== p0) $display("FAIL stall_accept: got %b/%0d want 1/%0d", pc_enab, imem_req_addr, p0); else passes++;
    advance();
    drive(1, 1, 1, 0, '0);
    checks++; if (imem_req_valid !== 1'b0 || pc_enab !== 1'b0) $display("FAIL stall_wait: got %b/%b want 0/0", imem_req_valid, pc_enab); else passes++;
    advance();
    settle();
  endtask
  task automatic test_redirect();
    settle();
    lat = 1;
    drive(1, 1, 0, 0, '0); advance();
    drive(1, 1, 0, 0, '0); advance();
    lat = 3;
    drive(1, 1, 0, 0, '0); advance();
    drive(1, 1, 0, 1, 5'h10);
    checks++; if (if_valid !== 1'b1) $display("FAIL redir_buffered: got %b want 1", if_valid); else passes++;
    checks++; if ({pc_load, pc_load_val, pc_enab, imem_req_valid} !== {1'b1, 5'h10, 2'b00}) $display("FAIL redir_load: got %b/%0d/%b/%b want 1/16/0/0", pc_load, pc_load_val, pc_enab, imem_req_valid); else passes++;
    advance();
    drive(1, 1, 0, 0, '0);
    checks++; if ({pc_load, pc_load_val, if_valid, imem_req_valid} !== 8'b0) $display("FAIL redir_after: got %b/%0d/%b/%b want all 0", pc_load, pc_load_val, if_valid, imem_req_valid); else passes++;
    advance();
    drive(1, 1, 0, 0, '0);
    checks++; if ({imem_rsp_valid, imem_req_valid, if_valid} !== 3'b100) $display("FAIL redir_drop: rsp/req/ifv got %b want 100", {imem_rsp_valid, imem_req_valid, if_valid}); else passes++;
    advance();
    drive(1, 1, 0, 0, '0);
    checks++; if ({if_valid, imem_req_valid, imem_req_addr} !== {2'b01, 5'h10}) $display("FAIL redir_next: got %b/%b/%0d want 0/1/16", if_valid, imem_req_valid, imem_req_addr); else passes++;
    advance();
    lat = 1;
    settle();
  endtask
  task automatic test_redirect_rsp_pop();
    settle();
    lat = 1;
    repeat (3) begin
      drive(1, 1, 0, 0, '0);
      advance();
    end
    drive(1, 1, 1, 1, 5'h08);
    checks++; if ({imem_rsp_valid, pc_load, pc_enab, imem_req_valid} !== 4'b1100) $display("FAIL rrp_same: rsp/load/enab/req got %b want 1100", {imem_rsp_valid, pc_load, pc_enab, imem_req_valid}); else passes++;
    advance();
    drive(1, 1, 0, 0, '0);
    checks++; if ({if_valid, imem_req_valid, imem_req_addr} !== {2'b01, 5'h08}) $display("FAIL rrp_after: got %b/%b/%0d want 0/1/8", if_valid, imem_req_valid, imem_req_addr); else passes++;
    advance();
    settle();
  endtask
  task automatic test_reset_mid();
    settle();
    lat = 1;
    drive(1, 1, 0, 0, '0); advance();
    drive(1, 1, 0, 0, '0); advance();
    lat = 3;
    drive(1, 1, 0, 0, '0); advance();
    drive(0, 1, 1, 0, '0);
    checks++; if ({imem_req_valid, pc_enab, pc_load, if_valid, if_instr, if_pc, imem_req_addr, pc_load_val} !== '0) $display("FAIL rstmid_outs: got %b%b%b%b %h %0d %0d %0d want 0", imem_req_valid, pc_enab, pc_load, if_valid, if_instr, if_pc, imem_req_addr, pc_load_val); else passes++;
    advance();
    repeat (2) begin
      drive(0, 1, 1, 1, 5'h05);
      checks++; if ({imem_req_valid, pc_load, if_valid} !== 3'b0) $display("FAIL rstmid_hold: got %b want 000", {imem_req_valid, pc_load, if_valid}); else passes++;
      advance();
    end
    drive(1, 1, 1, 0, '0);
    checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 5'h00}) $display("FAIL rstmid_release: got %b/%0d want 1/0", imem_req_valid, imem_req_addr); else passes++;
    advance();
    lat = 1;
    settle();
  endtask
  task automatic test_random();
    bit rd;
    logic [4:0] rpc;
    for (int k = 0; k < 400; k++) begin
      rd = $urandom_range(0, 11) == 0;
      rpc = 5'($urandom);
      lat = $urandom_range(1, 3);
      drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rd, rpc);
      checks++; if (imem_req_valid !== e_req) $display("FAIL rnd_req k=%0d: got %b want %b", k, imem_req_valid, e_req); else passes++;
      checks++; if (pc_enab !== (e_req && imem_req_ready)) $display("FAIL rnd_enab k=%0d: got %b want %b", k, pc_enab, e_req && imem_req_ready); else passes++;
      checks++; if ({pc_load, pc_load_val} !== {rd, rd ? rpc : 5'd0}) $display("FAIL rnd_load k=%0d: got %b/%0d want %b/%0d", k, pc_load, pc_load_val, rd, rd ? rpc : 5'd0); else passes++;
      if (e_req) begin
        checks++; if (imem_req_addr !== pc_m) $display("FAIL rnd_addr k=%0d: got %0d want %0d", k, imem_req_addr, pc_m); else passes++;
      end
      checks++; if (if_valid !== e_if) $display("FAIL rnd_ifv k=%0d: got %b want %b", k, if_valid, e_if); else passes++;
      if (e_if) begin
        checks++; if ({if_instr, if_pc} !== exp_q[0]) $display("FAIL rnd_out k=%0d: got %h want %h", k, {if_instr, if_pc}, exp_q[0]); else passes++;
      end
      advance();
    end
  endtask
  initial begin
    rst = 1'b0;
    imem_req_ready = 0; if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0; pc_in = '0; pc_m = '0;
    m_out = 0; m_kill = 0; m_delay = 0; m_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect();
    test_redirect_rsp_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly downstream of the program-counter counter. Reads the counter's current word address, issues one instruction-memory request at a time, and buffers returned instructions with their PC in a small FIFO for decode. Drives the counter's increment and load controls, and handles branch/jump redirects by reloading the counter and flushing in-flight work.

Parameters:
ADDR_WIDTH, 5, word-address width; equals the PC counter's WIDTH.
DATA_WIDTH, 32, instruction width.
FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
pc_in  input  ADDR_WIDTH  current PC from the counter's cnt_out
pc_enab  output  1  increment pulse to the counter's enab
pc_load  output  1  load strobe to the counter's load
pc_load_val  output  ADDR_WIDTH  load value to the counter's cnt_in
imem_req_valid  output  1  memory request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_WIDTH  request word address
imem_rsp_valid  input  1  response valid; in order, one cycle wide
imem_rsp_data  input  DATA_WIDTH  response instruction
redirect_valid  input  1  branch/jump taken
redirect_pc  input  ADDR_WIDTH  redirect target
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts
if_instr  output  DATA_WIDTH  instruction
if_pc  output  ADDR_WIDTH  PC of if_instr

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, req_pc=0; all outputs 0.
- States: IDLE (may issue), WAIT_RSP (one request outstanding), DROP (outstanding response to discard).
- Issue in IDLE: imem_req_valid=1 when FIFO count < FIFO_DEPTH and redirect_valid=0; imem_req_addr=pc_in (combinational).
- On imem_req_valid & imem_req_ready: pc_enab=1 for that cycle only; req_pc<=pc_in; IDLE->WAIT_RSP. imem_req_valid held stable while ready=0.
- WAIT_RSP & imem_rsp_valid: push {imem_rsp_data, req_pc} into the FIFO; ->IDLE. Issuing only when count<DEPTH guarantees a free slot.
- Earliest next request is the cycle after the response; the counter has already incremented by then.
- Decode handshake: if_valid = FIFO not empty; pop on if_valid & if_ready; if_instr/if_pc show the head entry; 0 when empty.
- Simultaneous push and pop: count unchanged; a full FIFO with a pop does not enable issue in the same cycle. Issue depends on the registered count.
- Redirect (highest priority):
  - pc_load=1 and pc_load_val=redirect_pc combinationally that cycle; pc_enab=0; imem_req_valid=0.
  - FIFO flushed, and the same-cycle pop is ignored.
  - WAIT_RSP without rsp -> DROP; WAIT_RSP with rsp -> response discarded, ->IDLE; IDLE/DROP unchanged.
- pc_load_val=0 when pc_load=0.
- DROP & imem_rsp_valid: discard the response, ->IDLE. A further redirect in DROP stays in DROP.
- PC wrap-around is owned by the counter (modulo 2^ADDR_WIDTH). The block applies no special handling.
- Latency: response to if_valid is 1 cycle (registered FIFO).

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty, state is WAIT_RSP, imem_rsp_valid=1 and no redirect, the response drives if_valid/if_instr/if_pc combinationally in the same cycle.
  - If if_ready=1 it is consumed and not written to the FIFO.
  - Otherwise it is pushed as normal.
- Undefined: no bypass; 1-cycle latency always.

Decomposition:
- Shared package fetch_pkg:
  - state encodings (IDLE=2'd0, WAIT_RSP=2'd1, DROP=2'd2)
  - NOP_INSTR constant 32'h00000013 (bench idle filler)
  - default widths
- One sub-module fetch_fifo (parameterised DEPTH x (DATA_WIDTH+ADDR_WIDTH)):
  - ports push, pop, flush, full, empty, count
  - same async active-low reset

Test Plan:
- Reset then pc_in=0, memory ready always, 1-cycle response latency, if_ready=1 -> requests to addresses 0,1,2,3 every other cycle; pc_enab one pulse per accept; if_pc 0,1,2,3 in order.
- if_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests issued, then imem_req_valid stays 0; one if_ready pulse -> one new request on the following cycle.
- imem_req_ready low for 3 cycles -> imem_req_valid and imem_req_addr stable; pc_enab only on the accepting cycle.
- Redirect to 5'h10 while in WAIT_RSP; response arrives 2 cycles later -> pc_load=1 with pc_load_val=16 for one cycle; FIFO empty; response dropped; next request address 16.
- Redirect in the same cycle as imem_rsp_valid and an if_ready pop -> response not pushed, FIFO empty, state IDLE, no pc_enab.
- rst asserted mid WAIT_RSP with 1 entry buffered -> all outputs 0 immediately, if_valid 0, no request until rst deasserted.
